// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data ports,
// one transaction at a time. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   input  logic        d_req_valid,
   input  logic        d_req_we,
   input  logic [3:0]  d_req_be,
   input  logic [31:0] d_req_addr,
   input  logic [31:0] d_req_wdata,
   output logic        d_req_ready,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_data,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {PORT_DATA = 1'b0, PORT_IF = 1'b1} port_t;

   state_t        state, state_nx;
   port_t         req_port;
   logic          req_we;
   logic [3:0]    req_be;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic [CW-1:0] wait_cnt;
   logic [31:0]   rdata_q;
   logic          grant_if;
   logic          accept_window;
   logic          accept;

`ifdef ARB_ROUND_ROBIN_EN
   port_t last_grant;
`else
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_cnt;
`endif

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant_if = 1'b0;
      if (if_req_valid && !d_req_valid) begin
         grant_if = 1'b1;
      end else if (if_req_valid && d_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
         grant_if = (last_grant == PORT_DATA);
`else
         grant_if = (starve_cnt == SW'(STARVE_MAX));
`endif
      end
   end

   assign accept_window = (state == IDLE) || (state == RESP);
   assign if_req_ready  = accept_window && if_req_valid && grant_if;
   assign d_req_ready   = accept_window && d_req_valid && !grant_if;
   assign accept        = if_req_ready || d_req_ready;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (wait_cnt == '0) state_nx = RESP;
         RESP:    state_nx = accept ? ISSUE : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset) begin
         state     <= IDLE;
         req_port  <= PORT_DATA;
         req_we    <= 1'b0;
         req_be    <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
         wait_cnt  <= '0;
         rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         // Seeded as IF so the first contested grant after reset goes to DATA.
         last_grant <= PORT_IF;
`else
         starve_cnt <= '0;
`endif
      end else begin
         state <= state_nx;
         if (accept) begin
            req_port  <= grant_if ? PORT_IF : PORT_DATA;
            req_we    <= grant_if ? 1'b0 : d_req_we;
            req_be    <= grant_if ? 4'hF : d_req_be;
            req_addr  <= grant_if ? if_req_addr : d_req_addr;
            req_wdata <= grant_if ? 32'h0 : d_req_wdata;
         end
         if (state == ISSUE) begin
            wait_cnt <= CW'(MEM_LAT - 1);
         end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
         end
         if (state == WAIT && wait_cnt == '0) begin
            rdata_q <= req_we ? 32'h0 : mem_rdata;
         end
`ifdef ARB_ROUND_ROBIN_EN
         if (accept) last_grant <= grant_if ? PORT_IF : PORT_DATA;
`else
         // Counts DATA wins over a waiting fetch; any IF grant clears it.
         if (accept) begin
            if (grant_if) begin
               starve_cnt <= '0;
            end else if (if_req_valid && starve_cnt != SW'(STARVE_MAX)) begin
               starve_cnt <= starve_cnt + SW'(1);
            end
         end
`endif
      end
   end

   assign busy      = (state != IDLE);
   assign mem_en    = (state == ISSUE);
   assign mem_we    = mem_en && req_we;
   assign mem_be    = mem_en ? req_be : 4'h0;
   assign mem_addr  = mem_en ? req_addr : 32'h0;
   assign mem_wdata = mem_en ? req_wdata : 32'h0;

   assign if_rsp_valid = (state == RESP) && (req_port == PORT_IF);
   assign d_rsp_valid  = (state == RESP) && (req_port == PORT_DATA);
   assign if_rsp_data  = if_rsp_valid ? rdata_q : 32'h0;
   assign d_rsp_data   = d_rsp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected issues/responses, monitors pop and compare.
module tb_mem_arbiter;
   localparam int LAT = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req_valid, if_req_ready, if_rsp_valid;
   logic [31:0] if_req_addr, if_rsp_data;
   logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
   logic [3:0]  d_req_be;
   logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
   logic        mem_en, mem_we, busy;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) dut (
      .clock(clock), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_be(d_req_be),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Memory model with LAT-cycle read latency; fixed words preloaded while in reset.
   logic [31:0] sim_mem [256] = '{default: 32'h0};
   logic [31:0] rd_pipe [LAT] = '{default: 32'h0};
   always @(posedge clock) begin
      if (!reset) begin
         sim_mem[0]    <= 32'h00500093;
         sim_mem[8'h80] <= 32'hCAFEF00D;
      end else if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we && mem_be[b]) sim_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (mem_en) rd_pipe[0] <= sim_mem[mem_addr[9:2]];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          cyc;
   } issue_t;

   typedef struct {
      logic        is_if;
      logic [31:0] data;
      int          cyc;
   } rsp_t;

   issue_t iss_q[$];
   rsp_t   rsp_q[$];
   int     checks = 0;
   int     errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic is_if, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
      issue_t i;
      rsp_t   r;
      i.we    = is_if ? 1'b0 : we;
      i.be    = is_if ? 4'hF : be;
      i.addr  = addr;
      i.wdata = is_if ? 32'h0 : wdata;
      i.cyc   = cyc + 1;
      r.is_if = is_if;
      r.data  = exp;
      r.cyc   = cyc + LAT + 2;
      iss_q.push_back(i);
      rsp_q.push_back(r);
   endtask

   // Monitor: compares every memory strobe and every response pulse against the queues.
   always @(negedge clock) begin
      issue_t i;
      rsp_t   r;
      if (if_rsp_valid && d_rsp_valid) check("rsp_exclusive", 1, 0);
      if (mem_en) begin
         if (iss_q.size() == 0) check("mem_en_unexpected", 1, 0);
         else begin
            i = iss_q.pop_front();
            check("issue_cycle", cyc, i.cyc);
            check("mem_we", mem_we, i.we);
            check("mem_be", mem_be, i.be);
            check("mem_addr", mem_addr, i.addr);
            check("mem_wdata", mem_wdata, i.wdata);
         end
      end
      if (if_rsp_valid || d_rsp_valid) begin
         if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
         else begin
            r = rsp_q.pop_front();
            check("rsp_port_if", if_rsp_valid, r.is_if);
            check("rsp_data", if_rsp_valid ? if_rsp_data : d_rsp_data, r.data);
            check("rsp_cycle", cyc, r.cyc);
         end
      end
   end

   task automatic xfer(input logic is_if, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
      int n = 0;
      if (is_if) begin
         if_req_valid = 1'b1; if_req_addr = addr;
      end else begin
         d_req_valid = 1'b1; d_req_we = we; d_req_be = be; d_req_addr = addr; d_req_wdata = wdata;
      end
      do begin
         @(negedge clock);
         n++;
      end while (!(is_if ? if_req_ready : d_req_ready) && n < 50);
      if (!(is_if ? if_req_ready : d_req_ready)) check("accept_timeout", 0, 1);
      else push_exp(is_if, we, be, addr, wdata, exp);
      @(posedge clock); #1;
      // Scramble request fields after accept: the transaction in flight must not see them.
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      if_req_addr = $urandom; d_req_addr = $urandom; d_req_wdata = $urandom;
      d_req_be = 4'($urandom); d_req_we = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((rsp_q.size() != 0 || iss_q.size() != 0 || busy) && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("drain_busy", busy, 0);
      check("drain_pending", rsp_q.size() + iss_q.size(), 0);
      @(posedge clock); #1;
   endtask

   logic exp_grant [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   logic acc_is_if[$];
   int   acc_cyc[$];

   initial begin
      reset = 1'b0;
      if_req_valid = 1'b1; if_req_addr = 32'h0;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_be = 4'h0; d_req_addr = 32'h200; d_req_wdata = 32'h0;

      // Reset held with both valids high: outputs quiet, readies follow IDLE rules.
      repeat (3) begin
         @(negedge clock);
         check("rst_if_rsp_valid", if_rsp_valid, 0);
         check("rst_d_rsp_valid", d_rsp_valid, 0);
         check("rst_mem_en", mem_en, 0);
         check("rst_busy", busy, 0);
         check("rst_d_req_ready", d_req_ready, 1);
         check("rst_if_req_ready", if_req_ready, 0);
      end
      @(posedge clock); #1;
      reset = 1'b1;

      // Continuous contention: DATA first, IF forced in after four straight DATA wins.
      begin
         int guard = 0;
         while (acc_is_if.size() < 10 && guard < 200) begin
            @(negedge clock);
            guard++;
            check("ready_exclusive", if_req_ready && d_req_ready, 0);
            if (if_req_ready) begin
               acc_is_if.push_back(1'b1); acc_cyc.push_back(cyc);
               push_exp(1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 32'h00500093);
            end else if (d_req_ready) begin
               acc_is_if.push_back(1'b0); acc_cyc.push_back(cyc);
               push_exp(1'b0, 1'b0, 4'h0, 32'h200, 32'h0, 32'hCAFEF00D);
            end
         end
         check("contention_accepts", acc_is_if.size(), 10);
         @(posedge clock); #1;
         if_req_valid = 1'b0; d_req_valid = 1'b0;
         for (int i = 0; i < acc_is_if.size(); i++) check("grant_order", acc_is_if[i], exp_grant[i]);
         for (int i = 1; i < acc_cyc.size(); i++) check("accept_interval", acc_cyc[i] - acc_cyc[i-1], LAT + 2);
      end
      drain();

      // Directed single transactions.
      xfer(1'b1, 1'b0, 4'h0,    32'h0,   32'h0,        32'h00500093);
      xfer(1'b0, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF, 32'h0);
      xfer(1'b0, 1'b0, 4'h0,    32'h100, 32'h0,        32'h0000BEEF);
      xfer(1'b0, 1'b1, 4'b1100, 32'h100, 32'h12345678, 32'h0);
      xfer(1'b1, 1'b0, 4'h0,    32'h100, 32'h0,        32'h1234BEEF);
      xfer(1'b0, 1'b0, 4'hF,    32'h102, 32'h0,        32'h1234BEEF);
      xfer(1'b0, 1'b0, 4'h0,    32'h200, 32'h0,        32'hCAFEF00D);
      drain();

      // Reset during the second WAIT cycle abandons the fetch.
      xfer(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h00500093);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      rsp_q.delete();
      @(negedge clock);
      check("midwait_busy", busy, 1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      check("post_rst_busy", busy, 0);
      check("post_rst_mem_en", mem_en, 0);
      check("post_rst_if_rsp", if_rsp_valid, 0);
      @(posedge clock); #1;
      xfer(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h00500093);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
